ace_snoop_responder: RTL and testbench

ACE_SNOOP_RESPONDER -- requirements
Module: ace_snoop_responder

---
 rtl/ace_snoop_responder.sv | 211 +++++++++++++++++++++
 tb/tb_ace_snoop_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder
//   Answers ACE snoops on behalf of a single-beat-per-line cache.
//   Flow: IDLE -> LOOKUP -> RESP -> [DATA] -> [UPDATE] -> IDLE.
//   One snoop is outstanding at a time. The responder yields to the
//   cache controller while cpu_busy is high, but only at acceptance.
//
//   Optional build macro: SNOOP_ERROR_RESP_EN. When defined,
//   unsupported snoop types answer crresp=00010 (Error). When it is
//   undefined, they answer crresp=00000.
//
// Ports
//   clk, reset (async, active-low)
//   AC : acvalid/acready, acaddr, acsnoop      - snoop address in
//   CR : crvalid/crready, crresp               - snoop response out
//        crresp = {WasUnique, IsShared, PassDirty, Error, DataTransfer}
//   CD : cdvalid/cdready, cddata, cdlast       - single-beat snoop data out
//   Tag lookup : snoop_lookup, snoop_addr -> snoop_hit, line_state, line_data
//   State update : snoop_state_we, snoop_new_state
//   Arbitration : cpu_busy in, snoop_active out
module ace_snoop_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WIDTH_STATE = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   acvalid,
    output logic                   acready,
    input  logic [ADDR_WIDTH-1:0]  acaddr,
    input  logic [3:0]             acsnoop,
    output logic                   crvalid,
    input  logic                   crready,
    output logic [4:0]             crresp,
    output logic                   cdvalid,
    input  logic                   cdready,
    output logic [DATA_WIDTH-1:0]  cddata,
    output logic                   cdlast,
    output logic                   snoop_lookup,
    output logic [ADDR_WIDTH-1:0]  snoop_addr,
    input  logic                   snoop_hit,
    input  logic [WIDTH_STATE-1:0] line_state,
    input  logic [DATA_WIDTH-1:0]  line_data,
    output logic                   snoop_state_we,
    output logic [WIDTH_STATE-1:0] snoop_new_state,
    input  logic                   cpu_busy,
    output logic                   snoop_active
);

    localparam logic [WIDTH_STATE-1:0] ST_UC = WIDTH_STATE'(0);
    localparam logic [WIDTH_STATE-1:0] ST_UD = WIDTH_STATE'(1);
    localparam logic [WIDTH_STATE-1:0] ST_SC = WIDTH_STATE'(2);
    localparam logic [WIDTH_STATE-1:0] ST_SD = WIDTH_STATE'(3);
    localparam logic [WIDTH_STATE-1:0] ST_I  = WIDTH_STATE'(4);

    localparam logic [3:0] SN_READ_ONCE     = 4'b0000;
    localparam logic [3:0] SN_READ_SHARED   = 4'b0001;
    localparam logic [3:0] SN_READ_UNIQUE   = 4'b0111;
    localparam logic [3:0] SN_CLEAN_INVALID = 4'b1001;
    localparam logic [3:0] SN_MAKE_INVALID  = 4'b1101;

    typedef enum logic [2:0] {IDLE, LOOKUP, RESP, DATA, UPDATE} state_t;

    state_t                 state;
    logic [3:0]             snoop_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   dt_q;
    logic                   upd_q;
    logic [WIDTH_STATE-1:0] ns_q;

    // Decision for the snoop, evaluated against the tag-lookup result
    // during LOOKUP. It is captured at the end of that cycle.
    logic                   line_valid;
    logic                   dirty;
    logic                   unique_l;
    logic [4:0]             resp_d;
    logic                   dt_d;
    logic                   upd_d;
    logic [WIDTH_STATE-1:0] ns_d;

    always_comb begin
        line_valid = snoop_hit && (line_state != ST_I);
        dirty      = (line_state == ST_UD) || (line_state == ST_SD);
        unique_l   = (line_state == ST_UC) || (line_state == ST_UD);
        resp_d     = '0;
        dt_d       = 1'b0;
        upd_d      = 1'b0;
        ns_d       = ST_I;
        case (snoop_q)
            SN_READ_ONCE: if (line_valid) begin
                resp_d = {unique_l, 1'b1, 1'b0, 1'b0, 1'b1};
                dt_d   = 1'b1;
            end
            SN_READ_SHARED: if (line_valid) begin
                resp_d = {unique_l, 1'b1, dirty, 1'b0, 1'b1};
                dt_d   = 1'b1;
                ns_d   = ST_SC;
                upd_d  = (line_state != ST_SC);
            end
            SN_READ_UNIQUE: if (line_valid) begin
                resp_d = {unique_l, 1'b0, dirty, 1'b0, 1'b1};
                dt_d   = 1'b1;
                upd_d  = 1'b1;
            end
            SN_CLEAN_INVALID: if (line_valid) begin
                resp_d = {unique_l, 1'b0, dirty, 1'b0, dirty};
                dt_d   = dirty;
                upd_d  = 1'b1;
            end
            SN_MAKE_INVALID: if (line_valid) begin
                resp_d = {unique_l, 1'b0, 1'b0, 1'b0, 1'b0};
                upd_d  = 1'b1;
            end
            default: begin
`ifdef SNOOP_ERROR_RESP_EN
                resp_d = 5'b00010;
`else
                resp_d = 5'b00000;
`endif
            end
        endcase
    end

    // Combinational so that a falling cpu_busy allows acceptance in the
    // same cycle. Gated by reset so that it reads 0 while reset is held.
    assign acready = reset && (state == IDLE) && !cpu_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            snoop_q         <= '0;
            data_q          <= '0;
            dt_q            <= 1'b0;
            upd_q           <= 1'b0;
            ns_q            <= '0;
            crvalid         <= 1'b0;
            crresp          <= '0;
            cdvalid         <= 1'b0;
            cddata          <= '0;
            cdlast          <= 1'b0;
            snoop_lookup    <= 1'b0;
            snoop_addr      <= '0;
            snoop_state_we  <= 1'b0;
            snoop_new_state <= '0;
            snoop_active    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acvalid && !cpu_busy) begin
                        snoop_addr   <= acaddr;
                        snoop_q      <= acsnoop;
                        snoop_lookup <= 1'b1;
                        snoop_active <= 1'b1;
                        state        <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    snoop_lookup <= 1'b0;
                    data_q       <= line_data;
                    dt_q         <= dt_d;
                    upd_q        <= upd_d;
                    ns_q         <= ns_d;
                    crresp       <= resp_d;
                    crvalid      <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (crready) begin
                        crvalid <= 1'b0;
                        crresp  <= '0;
                        if (dt_q) begin
                            cdvalid <= 1'b1;
                            cdlast  <= 1'b1;
                            cddata  <= data_q;
                            state   <= DATA;
                        end else if (upd_q) begin
                            snoop_state_we  <= 1'b1;
                            snoop_new_state <= ns_q;
                            state           <= UPDATE;
                        end else begin
                            snoop_active <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (cdready) begin
                        cdvalid <= 1'b0;
                        cdlast  <= 1'b0;
                        cddata  <= '0;
                        if (upd_q) begin
                            snoop_state_we  <= 1'b1;
                            snoop_new_state <= ns_q;
                            state           <= UPDATE;
                        end else begin
                            snoop_active <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                UPDATE: begin
                    snoop_state_we  <= 1'b0;
                    snoop_new_state <= '0;
                    snoop_active    <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Self-checking bench for ace_snoop_responder: directed scenarios followed
// by randomized snoops, all judged against a rule-level reference model.
module tb_ace_snoop_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        acvalid;
    logic        acready;
    logic [31:0] acaddr;
    logic [3:0]  acsnoop;
    logic        crvalid;
    logic        crready;
    logic [4:0]  crresp;
    logic        cdvalid;
    logic        cdready;
    logic [31:0] cddata;
    logic        cdlast;
    logic        snoop_lookup;
    logic [31:0] snoop_addr;
    logic        snoop_hit;
    logic [2:0]  line_state;
    logic [31:0] line_data;
    logic        snoop_state_we;
    logic [2:0]  snoop_new_state;
    logic        cpu_busy;
    logic        snoop_active;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    ace_snoop_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WIDTH_STATE(3)) dut (
        .clk(clk), .reset(reset),
        .acvalid(acvalid), .acready(acready), .acaddr(acaddr), .acsnoop(acsnoop),
        .crvalid(crvalid), .crready(crready), .crresp(crresp),
        .cdvalid(cdvalid), .cdready(cdready), .cddata(cddata), .cdlast(cdlast),
        .snoop_lookup(snoop_lookup), .snoop_addr(snoop_addr),
        .snoop_hit(snoop_hit), .line_state(line_state), .line_data(line_data),
        .snoop_state_we(snoop_state_we), .snoop_new_state(snoop_new_state),
        .cpu_busy(cpu_busy), .snoop_active(snoop_active)
    );

    typedef struct packed {
        logic [4:0] resp;
        logic       dt;
        logic       upd;
        logic [2:0] ns;
    } exp_t;

    // Reference model: the coherence rules written per snoop type by name.
    function automatic exp_t model(input logic [3:0] op, input logic hit, input logic [2:0] st);
        exp_t e;
        logic wu, sh, pd, dt, supported, present, is_dirty;
        e = '0;
        wu = 0; sh = 0; pd = 0; dt = 0;
        supported = (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0111) ||
                    (op == 4'b1001) || (op == 4'b1101);
        present  = hit && (st != 3'b100);
        is_dirty = (st == 3'b001) || (st == 3'b011);
        if (!supported) begin
`ifdef SNOOP_ERROR_RESP_EN
            e.resp = 5'b00010;
`endif
            return e;
        end
        if (!present) return e;
        wu = (st == 3'b000) || (st == 3'b001);
        if (op == 4'b0000) begin dt = 1; sh = 1; end
        if (op == 4'b0001) begin dt = 1; sh = 1; pd = is_dirty; e.ns = 3'b010; e.upd = (st != 3'b010); end
        if (op == 4'b0111) begin dt = 1; pd = is_dirty; e.ns = 3'b100; e.upd = 1; end
        if (op == 4'b1001) begin dt = is_dirty; pd = is_dirty; e.ns = 3'b100; e.upd = 1; end
        if (op == 4'b1101) begin e.ns = 3'b100; e.upd = 1; end
        e.dt   = dt;
        e.resp = {wu, sh, pd, 1'b0, dt};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] all_outs();
        return {acready, crvalid, cdvalid, cdlast, snoop_lookup, snoop_state_we,
                snoop_active, crresp, cddata, snoop_addr, snoop_new_state};
    endfunction

    // One complete snoop: busy = cycles cpu_busy holds off acceptance,
    // crd/cdd = cycles crready/cdready are held low.
    task automatic do_snoop(input logic [3:0] op, input logic hit, input logic [2:0] st,
                            input logic [31:0] data, input int busy, input int crd, input int cdd);
        exp_t        e;
        logic [31:0] addr;
        int          beats, wes, wait_cnt;
        logic [2:0]  ns_seen;
        e = model(op, hit, st);
        addr = $urandom;
        beats = 0; wes = 0; wait_cnt = 0; ns_seen = '0;
        @(negedge clk);
        acaddr = addr; acsnoop = op; snoop_hit = hit; line_state = st; line_data = data;
        acvalid = 1'b1; cpu_busy = (busy > 0);
        for (int i = 0; i < busy; i++) begin
            #1 chk("busy_acready", acready, 0);
            chk("busy_no_accept", snoop_active, 0);
            @(negedge clk);
        end
        cpu_busy = 1'b0;
        #1 chk("idle_acready", acready, 1);
        @(posedge clk);
        #1 acvalid = 1'b0;
        cpu_busy = $urandom_range(0, 1);
        @(negedge clk);
        chk("lookup_pulse", snoop_lookup, 1);
        chk("lookup_addr", snoop_addr, addr);
        chk("active_acready", acready, 0);
        chk("active", snoop_active, 1);
        @(negedge clk);
        chk("lookup_single", snoop_lookup, 0);
        chk("crvalid", crvalid, 1);
        chk("crresp", crresp, e.resp);
        for (int i = 0; i < crd; i++) begin
            @(negedge clk);
            chk("crvalid_hold", crvalid, 1);
            chk("crresp_hold", crresp, e.resp);
        end
        crready = 1'b1;
        @(posedge clk);
        #1 crready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!snoop_active) break;
            if (snoop_state_we) begin wes++; ns_seen = snoop_new_state; end
            if (cdvalid) begin
                if (wait_cnt == cdd) begin
                    chk("cddata", cddata, data);
                    chk("cdlast", cdlast, 1);
                    cdready = 1'b1;
                    beats++;
                end else wait_cnt++;
            end else cdready = 1'b0;
        end
        cdready = 1'b0;
        cpu_busy = 1'b0;
        chk("return_idle", snoop_active, 0);
        chk("data_beats", beats, e.dt ? 1 : 0);
        chk("update_pulses", wes, e.upd ? 1 : 0);
        chk("new_state", ns_seen, e.upd ? e.ns : 3'b000);
    endtask

    initial begin
        reset = 1'b0; acvalid = 0; acaddr = '0; acsnoop = '0; crready = 0; cdready = 0;
        snoop_hit = 0; line_state = '0; line_data = '0; cpu_busy = 0;
        #1 chk("reset_outputs", all_outs(), '0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_acready", acready, 1);
        cpu_busy = 1'b1;
        #1 chk("post_reset_busy_acready", acready, 0);
        cpu_busy = 1'b0;

        // ReadShared to UD hit, DEADBEEF
        do_snoop(4'b0001, 1, 3'b001, 32'hDEADBEEF, 0, 0, 0);
        // ReadUnique to SC hit, crready low 3 cycles
        do_snoop(4'b0111, 1, 3'b010, 32'h12345678, 0, 3, 1);
        // MakeInvalid to SD hit
        do_snoop(4'b1101, 1, 3'b011, 32'hCAFEF00D, 0, 0, 0);
        // cpu_busy blocks acceptance for 4 cycles
        do_snoop(4'b0000, 1, 3'b000, 32'hA5A5A5A5, 4, 0, 0);
        // unsupported type
        do_snoop(4'b0010, 1, 3'b001, 32'h0BADC0DE, 0, 1, 0);
        // miss and I-state
        do_snoop(4'b0111, 0, 3'b001, 32'h11111111, 0, 0, 0);
        do_snoop(4'b1001, 1, 3'b100, 32'h22222222, 0, 0, 0);
        // ReadShared to SC: no update
        do_snoop(4'b0001, 1, 3'b010, 32'h33333333, 0, 0, 0);

        // Reset asserted while in DATA
        @(negedge clk);
        acaddr = 32'h4000; acsnoop = 4'b0111; snoop_hit = 1; line_state = 3'b001;
        line_data = 32'h55AA55AA; acvalid = 1'b1;
        @(posedge clk);
        #1 acvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        crready = 1'b1;
        @(posedge clk);
        #1 crready = 1'b0;
        @(negedge clk);
        chk("in_data_cdvalid", cdvalid, 1);
        reset = 1'b0;
        #1 chk("mid_reset_outputs", all_outs(), '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_no_we", snoop_state_we, 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("release_no_we", snoop_state_we, 0);
            chk("release_acready", acready, 1);
        end

        // Randomized snoops
        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            logic [3:0] ops [8];
            ops = '{4'b0000, 4'b0001, 4'b0111, 4'b1001, 4'b1101, 4'b0010, 4'b1111, 4'b0100};
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) op = 4'($urandom);
            do_snoop(op, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 4)), $urandom,
                     $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
